// File: rtl/packet_filter_fifo_if.sv
// Flit handshake bundle between the untrusted source, the packet filter and the router local port.
// slave is the filter's view; master is the view of the environment driving it.
interface packet_filter_fifo_if #(
    parameter int FLIT_WIDTH = 32
) ();
    logic                  rx;
    logic [FLIT_WIDTH-1:0] data_in;
    logic                  credit_o;
    logic                  tx;
    logic [FLIT_WIDTH-1:0] data_out;
    logic                  credit_i;

    modport slave (
        input  rx, data_in, credit_i,
        output credit_o, tx, data_out
    );

    modport master (
        output rx, data_in, credit_i,
        input  credit_o, tx, data_out
    );
endinterface

// File: rtl/packet_filter_fifo.sv
// Buffered local-port packet filter: checks ADDR/SIZE header checksums, forwards valid packets, pads stalled ones.
// Optional statistics counters are built only when PKT_FILTER_STATS_EN is defined.
module packet_filter_fifo #(
    parameter int         FLIT_WIDTH  = 32,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] X_MAX       = 8'd3,
    parameter logic [7:0] Y_MAX       = 8'd3,
    parameter int         TIMEOUT_MAX = 10,
    parameter int         MAX_SIZE    = 1024,
    parameter int         STAT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    packet_filter_fifo_if.slave   bus,
    output logic                  busy,
    output logic [STAT_WIDTH-1:0] drop_cnt,
    output logic [STAT_WIDTH-1:0] tmo_cnt
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam int          TW         = $clog2(TIMEOUT_MAX);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_MAX - 1);
    localparam logic [23:0] MAX_SIZE_V = 24'(MAX_SIZE);
    localparam logic [15:0] IV         = {X_MAX, Y_MAX};

    typedef enum logic [2:0] {
        S_ADDR,
        S_SIZE,
        S_EADDR,
        S_ESIZE,
        S_PAYLOAD,
        S_PAD
    } state_t;

    state_t                state, state_n;
    logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic                  empty, full, push, pop;
    logic [FLIT_WIDTH-1:0] head;
    logic [FLIT_WIDTH-1:0] addr_q, size_q;
    logic [23:0]           rem;
    logic [TW-1:0]         timer;
    logic                  achk_ok, size_ok, timeout;
    logic                  load_addr, load_size, dec_rem;
    logic                  tx_c;
    logic [FLIT_WIDTH-1:0] dout_c;

    function automatic logic [7:0] addr_chk(input logic [15:0] addr);
        logic [7:0] chk;
        for (int i = 0; i < 8; i++)
            chk[i] = addr[2*i] ^ addr[2*i+1] ^ IV[2*i] ^ IV[2*i+1];
        return chk;
    endfunction

    function automatic logic [7:0] size_chk(input logic [23:0] size, input logic [7:0] achk);
        logic [7:0] chk;
        for (int i = 0; i < 8; i++)
            chk[i] = size[3*i] ^ size[3*i+1] ^ size[3*i+2] ^ achk[i];
        return chk;
    endfunction

    // Input FIFO: pointers carry one extra wrap bit to tell full from empty.
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push         = bus.rx && !full;
    assign head         = mem[rd_ptr[AW-1:0]];
    assign bus.credit_o = !full;

    // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= bus.data_in;
    end

    // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign achk_ok = (head[23:16] == addr_chk(head[15:0]));
    assign size_ok = (head[31:24] == size_chk(head[23:0], addr_q[23:16]))
                     && (head[23:0] != 24'd0) && (head[23:0] <= MAX_SIZE_V);
    assign timeout = ((state == S_SIZE) || (state == S_PAYLOAD)) && empty && (timer == TMR_LAST);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        load_addr = 1'b0;
        load_size = 1'b0;
        dec_rem   = 1'b0;
        tx_c      = 1'b0;
        dout_c    = '0;
        case (state)
            S_ADDR: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (achk_ok) begin
                        load_addr = 1'b1;
                        state_n   = S_SIZE;
                    end
                end
            end
            S_SIZE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (size_ok) begin
                        load_size = 1'b1;
                        state_n   = S_EADDR;
                    end else begin
                        state_n   = S_ADDR;
                    end
                end else if (timeout) begin
                    state_n = S_ADDR;
                end
            end
            S_EADDR: begin
                tx_c   = 1'b1;
                dout_c = addr_q;
                if (bus.credit_i)
                    state_n = S_ESIZE;
            end
            S_ESIZE: begin
                tx_c   = 1'b1;
                dout_c = size_q;
                if (bus.credit_i)
                    state_n = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                tx_c   = !empty;
                dout_c = head;
                if (!empty && bus.credit_i) begin
                    pop     = 1'b1;
                    dec_rem = 1'b1;
                    if (rem == 24'd1)
                        state_n = S_ADDR;
                end else if (timeout) begin
                    state_n = S_PAD;
                end
            end
            S_PAD: begin
                tx_c = 1'b1;
                if (bus.credit_i) begin
                    dec_rem = 1'b1;
                    if (rem == 24'd1)
                        state_n = S_ADDR;
                end
            end
            default: state_n = S_ADDR;
        endcase
    end

    assign bus.tx       = tx_c;
    assign bus.data_out = dout_c;
    assign busy         = (state != S_ADDR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_ADDR;
            addr_q <= '0;
            size_q <= '0;
            rem    <= '0;
            timer  <= '0;
        end else begin
            state <= state_n;
            if (load_addr)
                addr_q <= head;
            if (load_size) begin
                size_q <= head;
                rem    <= head[23:0];
            end else if (dec_rem) begin
                rem <= rem - 1'b1;
            end
            // Timer only runs while starved in a waiting state; any state change restarts it.
            if ((state_n != state) || !empty || !((state == S_SIZE) || (state == S_PAYLOAD)))
                timer <= '0;
            else
                timer <= timer + 1'b1;
        end
    end

`ifdef PKT_FILTER_STATS_EN
    logic drop_ev, tmo_ev;

    assign drop_ev = pop && (((state == S_ADDR) && !achk_ok) || ((state == S_SIZE) && !size_ok));
    assign tmo_ev  = timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            if (drop_ev && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 1'b1;
            if (tmo_ev && (tmo_cnt != '1))
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign drop_cnt = '0;
    assign tmo_cnt  = '0;
`endif

endmodule

// File: tb/tb_packet_filter_fifo.sv
// Directed bench for packet_filter_fifo: forwarding, header rejection, timeout padding, backpressure and reset.
module tb_packet_filter_fifo;

    localparam int FW = 32;
    localparam int SW = 16;
    localparam int TIMEOUT_MAX = 10;
`ifdef PKT_FILTER_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    localparam logic [FW-1:0] HA  = 32'h0011_0102;
    localparam logic [FW-1:0] HS3 = 32'h1100_0003;
    localparam logic [FW-1:0] HS4 = 32'h1000_0004;
    localparam logic [FW-1:0] P1  = 32'hDEAD_0001;
    localparam logic [FW-1:0] P2  = 32'hBEEF_0002;
    localparam logic [FW-1:0] P3  = 32'hCAFE_0003;
    localparam logic [FW-1:0] P4  = 32'hF00D_0004;

    logic          clk = 1'b0;
    logic          reset;
    logic          busy;
    logic [SW-1:0] drop_cnt, tmo_cnt;

    packet_filter_fifo_if #(.FLIT_WIDTH(FW)) bus ();

    packet_filter_fifo #(
        .FLIT_WIDTH (FW),
        .FIFO_DEPTH (4),
        .X_MAX      (8'd3),
        .Y_MAX      (8'd3),
        .TIMEOUT_MAX(TIMEOUT_MAX),
        .MAX_SIZE   (1024),
        .STAT_WIDTH (SW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .drop_cnt(drop_cnt),
        .tmo_cnt (tmo_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic [FW-1:0] out_q[$];
    int            stamp_q[$];
    logic [FW-1:0] exp_pkt[5];

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change #1 after a rising edge, so the falling edge sees the values the next edge will use.
    always @(negedge clk) begin
        if (reset && bus.tx && bus.credit_i) begin
            out_q.push_back(bus.data_out);
            stamp_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        bus.rx = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        out_q.delete();
        stamp_q.delete();
    endtask

    task automatic push(input logic [FW-1:0] f);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        bus.rx      = 1'b1;
        bus.data_in = f;
        do begin
            @(negedge clk);
            ok = bus.credit_o;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        bus.rx = 1'b0;
        check("push_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_out(input int n, input string tag);
        int k;
        k = 0;
        while (out_q.size() < n && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, 64'(out_q.size()), 64'(n));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt1();
        push(HA);
        push(HS3);
        push(P1);
        push(P2);
        push(P3);
    endtask

    task automatic cmp_pkt1(input string tag);
        exp_pkt = '{HA, HS3, P1, P2, P3};
        for (int i = 0; i < 5; i++)
            check($sformatf("%s_flit%0d", tag, i), 64'(out_q[i]), 64'(exp_pkt[i]));
    endtask

    initial begin
        reset        = 1'b0;
        bus.rx       = 1'b0;
        bus.data_in  = '0;
        bus.credit_i = 1'b1;
        #2;
        check("rst_tx", 64'(bus.tx), 64'd0);
        check("rst_credit_o", 64'(bus.credit_o), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data_out", 64'(bus.data_out), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_tmo", 64'(tmo_cnt), 64'd0);

        // 1: clean packet forwarded unchanged
        do_reset();
        send_pkt1();
        wait_out(5, "s1_count");
        cmp_pkt1("s1");
        idle(4);
        check("s1_no_extra", 64'(out_q.size()), 64'd5);
        check("s1_drop", 64'(drop_cnt), 64'd0);
        check("s1_busy", 64'(busy), 64'd0);

        // 2: bad ADDR checksum dropped ahead of a good packet
        do_reset();
        push(32'h0022_0102);
        send_pkt1();
        wait_out(5, "s2_count");
        cmp_pkt1("s2");
        idle(4);
        check("s2_no_extra", 64'(out_q.size()), 64'd5);
        check("s2_drop", 64'(drop_cnt), STATS_ON ? 64'd1 : 64'd0);

        // 3: bad SIZE checksum discards the whole header
        do_reset();
        push(HA);
        push(32'h1200_0003);
        idle(4);
        check("s3_no_output", 64'(out_q.size()), 64'd0);
        check("s3_drop", 64'(drop_cnt), STATS_ON ? 64'd1 : 64'd0);
        check("s3_busy", 64'(busy), 64'd0);

        // 5: backpressure fills the FIFO; nothing lost or duplicated
        do_reset();
        bus.credit_i = 1'b0;
        push(HA);
        push(HS4);
        push(P1);
        push(P2);
        push(P3);
        push(P4);
        check("s5_credit_full", 64'(bus.credit_o), 64'd0);
        check("s5_busy", 64'(busy), 64'd1);
        check("s5_tx_hold", 64'(bus.tx), 64'd1);
        check("s5_hold_addr", 64'(bus.data_out), 64'(HA));
        bus.credit_i = 1'b1;
        wait_out(6, "s5_count");
        exp_pkt = '{HS4, P1, P2, P3, P4};
        check("s5_flit0", 64'(out_q[0]), 64'(HA));
        for (int i = 0; i < 5; i++)
            check($sformatf("s5_flit%0d", i + 1), 64'(out_q[i+1]), 64'(exp_pkt[i]));
        idle(4);
        check("s5_no_extra", 64'(out_q.size()), 64'd6);
        check("s5_credit_free", 64'(bus.credit_o), 64'd1);

        // 4: stalled payload padded with null flits after TIMEOUT_MAX empty cycles
        do_reset();
        push(HA);
        push(HS3);
        push(P1);
        wait_out(5, "s4_count");
        check("s4_flit0", 64'(out_q[0]), 64'(HA));
        check("s4_flit1", 64'(out_q[1]), 64'(HS3));
        check("s4_flit2", 64'(out_q[2]), 64'(P1));
        check("s4_pad0", 64'(out_q[3]), 64'd0);
        check("s4_pad1", 64'(out_q[4]), 64'd0);
        check("s4_pad_delay", 64'(stamp_q[3] - stamp_q[2]), 64'(TIMEOUT_MAX + 1));
        check("s4_busy", 64'(busy), 64'd0);
        check("s4_tmo", 64'(tmo_cnt), STATS_ON ? 64'd1 : 64'd0);
        idle(3);
        check("s4_no_extra", 64'(out_q.size()), 64'd5);

        // 6: reset mid-payload (rem=2) abandons the packet; replay is clean
        out_q.delete();
        stamp_q.delete();
        push(HA);
        push(HS3);
        push(P1);
        wait_out(3, "s6_pre_count");
        check("s6_pre_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #2;
        check("s6_rst_tx", 64'(bus.tx), 64'd0);
        check("s6_rst_busy", 64'(busy), 64'd0);
        check("s6_rst_credit_o", 64'(bus.credit_o), 64'd1);
        check("s6_rst_data_out", 64'(bus.data_out), 64'd0);
        check("s6_rst_tmo", 64'(tmo_cnt), 64'd0);
        @(negedge clk);
        check("s6_rst_tx_hold", 64'(bus.tx), 64'd0);
        do_reset();
        send_pkt1();
        wait_out(5, "s6_count");
        cmp_pkt1("s6");
        idle(4);
        check("s6_no_extra", 64'(out_q.size()), 64'd5);
        check("s6_drop", 64'(drop_cnt), 64'd0);
        check("s6_tmo", 64'(tmo_cnt), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
